// File: rtl/ecore_pwm_pkg.sv
// Shared types and default sizes for the multi-channel complementary PWM block.
// Holds the dead-time FSM state enum used by every channel instance.
package ecore_pwm_pkg;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_DT_W  = 8;

    typedef enum logic [1:0] {
        LOW_ON  = 2'd0,
        DEAD    = 2'd1,
        HIGH_ON = 2'd2
    } dt_state_e;

endpackage

// File: rtl/ecore_pwm_deadtime.sv
// Per-channel dead-time generator: turns a raw PWM level into a registered
// complementary high/low pair with a break-before-make gap between them.
module ecore_pwm_deadtime
    import ecore_pwm_pkg::*;
#(
    parameter int DT_W = DEF_DT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            force_off,
    input  logic            raw,
    input  logic [DT_W-1:0] deadtime,
    output logic            pwm_high,
    output logic            pwm_low
);

    dt_state_e       state_q;
    dt_state_e       state_d;
    logic [DT_W-1:0] dt_cnt_q;
    logic [DT_W-1:0] dt_cnt_d;
    logic            target_q;
    logic            target_d;
    logic            high_q;
    logic            high_d;
    logic            low_q;
    logic            low_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LOW_ON;
            dt_cnt_q <= '0;
            target_q <= 1'b0;
            high_q   <= 1'b0;
            low_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            dt_cnt_q <= dt_cnt_d;
            target_q <= target_d;
            high_q   <= high_d;
            low_q    <= low_d;
        end
    end

    // target_q remembers which side the channel is heading to, so a raw
    // change while DEAD is detected against it and restarts the gap.
    always_comb begin
        state_d  = state_q;
        dt_cnt_d = dt_cnt_q;
        target_d = target_q;
        if (force_off) begin
            state_d  = LOW_ON;
            dt_cnt_d = '0;
            target_d = 1'b0;
        end else if (en) begin
            unique case (state_q)
                LOW_ON: begin
                    if (raw) begin
                        target_d = 1'b1;
                        if (deadtime == '0) begin
                            state_d = HIGH_ON;
                        end else begin
                            state_d  = DEAD;
                            dt_cnt_d = deadtime;
                        end
                    end
                end
                HIGH_ON: begin
                    if (!raw) begin
                        target_d = 1'b0;
                        if (deadtime == '0) begin
                            state_d = LOW_ON;
                        end else begin
                            state_d  = DEAD;
                            dt_cnt_d = deadtime;
                        end
                    end
                end
                DEAD: begin
                    if (raw != target_q) begin
                        target_d = raw;
                        if (deadtime == '0) begin
                            if (raw) begin
                                state_d = HIGH_ON;
                            end else begin
                                state_d = LOW_ON;
                            end
                        end else begin
                            dt_cnt_d = deadtime;
                        end
                    end else if (dt_cnt_q <= DT_W'(1)) begin
                        if (target_q) begin
                            state_d = HIGH_ON;
                        end else begin
                            state_d = LOW_ON;
                        end
                    end else begin
                        dt_cnt_d = dt_cnt_q - DT_W'(1);
                    end
                end
                default: begin
                    state_d  = LOW_ON;
                    target_d = 1'b0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they can
    // never both be high and they settle one cycle after the raw level.
    always_comb begin
        high_d = high_q;
        low_d  = low_q;
        if (force_off) begin
            high_d = 1'b0;
            low_d  = 1'b0;
        end else if (en) begin
            high_d = (state_d == HIGH_ON);
            low_d  = (state_d == LOW_ON);
        end
    end

    assign pwm_high = high_q;
    assign pwm_low  = low_q;

endmodule

// File: rtl/ecore_pwm_multi.sv
// Multi-channel complementary PWM: shared up-counter, shadowed period/duty/dead-time
// loaded on wrap, per-channel dead-time FSMs. Define PWM_FAULT_IN_EN for fault ports.
module ecore_pwm_multi
    import ecore_pwm_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int DT_W  = DEF_DT_W
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  en_i,
    input  logic [CNT_W-1:0]      period_i,
    input  logic [N_CH*CNT_W-1:0] duty_i,
    input  logic [DT_W-1:0]       deadtime_i,
    input  logic                  update_i,
`ifdef PWM_FAULT_IN_EN
    input  logic                  fault_i,
    input  logic                  fault_clr_i,
`endif
    output logic [N_CH-1:0]       pwm_high_o,
    output logic [N_CH-1:0]       pwm_low_o,
    output logic                  period_tick_o,
    output logic                  update_pending_o
);

    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      period_act_q;
    logic [N_CH*CNT_W-1:0] duty_act_q;
    logic [DT_W-1:0]       deadtime_act_q;
    logic                  pending_q;
    logic                  tick_q;
    logic                  wrap;
    logic                  load;
    logic                  force_off;
    logic [N_CH-1:0]       raw;

    // The >= compare keeps the counter bounded even if it ever sits above period.
    assign wrap = en_i && (cnt_q >= period_act_q);
    assign load = wrap && (pending_q || update_i);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q          <= '0;
            period_act_q   <= '0;
            duty_act_q     <= '0;
            deadtime_act_q <= '0;
            pending_q      <= 1'b0;
            tick_q         <= 1'b0;
        end else begin
            if (en_i) begin
                cnt_q <= wrap ? '0 : cnt_q + CNT_W'(1);
            end
            tick_q <= wrap;
            if (load) begin
                period_act_q   <= period_i;
                duty_act_q     <= duty_i;
                deadtime_act_q <= deadtime_i;
                pending_q      <= 1'b0;
            end else if (update_i) begin
                pending_q <= 1'b1;
            end
        end
    end

`ifdef PWM_FAULT_IN_EN
    logic fault_q;

    // A new fault wins over a clear arriving in the same cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            fault_q <= 1'b0;
        end else if (fault_i) begin
            fault_q <= 1'b1;
        end else if (fault_clr_i) begin
            fault_q <= 1'b0;
        end
    end

    assign force_off = fault_i || fault_q;
`else
    assign force_off = 1'b0;
`endif

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign raw[k] = (cnt_q < duty_act_q[k*CNT_W +: CNT_W]);

        ecore_pwm_deadtime #(
            .DT_W (DT_W)
        ) u_deadtime (
            .clk       (wb_clk_i),
            .rst       (wb_rst_i),
            .en        (en_i),
            .force_off (force_off),
            .raw       (raw[k]),
            .deadtime  (deadtime_act_q),
            .pwm_high  (pwm_high_o[k]),
            .pwm_low   (pwm_low_o[k])
        );
    end

    assign period_tick_o    = tick_q;
    assign update_pending_o = pending_q;

endmodule

// File: tb/tb_ecore_pwm_multi.sv
// Self-checking bench for ecore_pwm_multi: directed scenarios plus random traffic,
// compared every cycle against a history-based reference model.
`timescale 1ns/1ps
module tb_ecore_pwm_multi;

    localparam int N_CH    = 4;
    localparam int CNT_W   = 16;
    localparam int DT_W    = 8;
    localparam int SETTLED = 1000;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic                  update;
    logic [CNT_W-1:0]      period;
    logic [N_CH*CNT_W-1:0] duty;
    logic [DT_W-1:0]       deadtime;
    logic [N_CH-1:0]       pwm_high;
    logic [N_CH-1:0]       pwm_low;
    logic                  tick;
    logic                  pending;
`ifdef PWM_FAULT_IN_EN
    logic                  fault;
    logic                  fault_clr;
`endif

    always #5 clk = ~clk;

    ecore_pwm_multi #(
        .N_CH  (N_CH),
        .CNT_W (CNT_W),
        .DT_W  (DT_W)
    ) dut (
        .wb_clk_i         (clk),
        .wb_rst_i         (rst),
        .en_i             (en),
        .period_i         (period),
        .duty_i           (duty),
        .deadtime_i       (deadtime),
        .update_i         (update),
`ifdef PWM_FAULT_IN_EN
        .fault_i          (fault),
        .fault_clr_i      (fault_clr),
`endif
        .pwm_high_o       (pwm_high),
        .pwm_low_o        (pwm_low),
        .period_tick_o    (tick),
        .update_pending_o (pending)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: counter/shadow rules plus, per channel, the length of
    // time the raw level has been stable versus the dead time in force when it changed.
    int              m_cnt;
    int              m_period;
    int              m_dt;
    int              m_duty [N_CH];
    bit              m_pending;
    bit              m_fault;
    bit              m_raw  [N_CH];
    int              m_len  [N_CH];
    int              m_dsel [N_CH];
    logic [N_CH-1:0] exp_high;
    logic [N_CH-1:0] exp_low;
    logic            exp_tick;

    int t_high [N_CH];
    int t_low  [N_CH];
    int t_off  [N_CH];
    int t_tick;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_cnt     = 0;
        m_period  = 0;
        m_dt      = 0;
        m_pending = 0;
        m_fault   = 0;
        for (int k = 0; k < N_CH; k++) begin
            m_duty[k] = 0;
            m_raw[k]  = 0;
            m_len[k]  = SETTLED;
            m_dsel[k] = 0;
        end
        exp_high = '0;
        exp_low  = '1;
        exp_tick = 1'b0;
    endtask

    task automatic modelEdge();
        bit wrap;
        bit force_off;
        bit r;
        if (rst) begin
            modelReset();
            return;
        end
        force_off = 1'b0;
`ifdef PWM_FAULT_IN_EN
        force_off = fault || m_fault;
        if (fault) m_fault = 1'b1;
        else if (fault_clr) m_fault = 1'b0;
`endif
        wrap     = en && (m_cnt >= m_period);
        exp_tick = wrap;
        for (int k = 0; k < N_CH; k++) begin
            if (force_off) begin
                exp_high[k] = 1'b0;
                exp_low[k]  = 1'b0;
                m_raw[k]    = 1'b0;
                m_len[k]    = SETTLED;
            end else if (en) begin
                r = (m_cnt < m_duty[k]);
                if (r != m_raw[k]) begin
                    m_raw[k]  = r;
                    m_len[k]  = 0;
                    m_dsel[k] = m_dt;
                end else if (m_len[k] < SETTLED) begin
                    m_len[k]++;
                end
                exp_high[k] = r && (m_len[k] >= m_dsel[k]);
                exp_low[k]  = !r && (m_len[k] >= m_dsel[k]);
            end
        end
        if (en) m_cnt = wrap ? 0 : m_cnt + 1;
        if (wrap && (m_pending || update)) begin
            m_period  = int'(period);
            m_dt      = int'(deadtime);
            for (int k = 0; k < N_CH; k++) m_duty[k] = int'(duty[k*CNT_W +: CNT_W]);
            m_pending = 1'b0;
        end else if (update) begin
            m_pending = 1'b1;
        end
    endtask

    task automatic clearTally();
        for (int k = 0; k < N_CH; k++) begin
            t_high[k] = 0;
            t_low[k]  = 0;
            t_off[k]  = 0;
        end
        t_tick = 0;
    endtask

    // One clock: advance the model at the edge, then compare 1 ns later.
    task automatic applyStimulus(input string tag);
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput({tag, "/high"}, 8'(pwm_high), 8'(exp_high));
        checkOutput({tag, "/low"}, 8'(pwm_low), 8'(exp_low));
        checkOutput({tag, "/tick"}, 8'(tick), 8'(exp_tick));
        checkOutput({tag, "/pending"}, 8'(pending), 8'(m_pending));
        for (int k = 0; k < N_CH; k++) begin
            if (pwm_high[k] === 1'b1) t_high[k]++;
            if (pwm_low[k] === 1'b1) t_low[k]++;
            if (pwm_high[k] === 1'b0 && pwm_low[k] === 1'b0) t_off[k]++;
        end
        if (tick === 1'b1) t_tick++;
    endtask

    task automatic runCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(tag);
    endtask

    task automatic setDuty(input int k, input int v);
        duty[k*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    task automatic pulseUpdate(input string tag);
        update = 1'b1;
        applyStimulus(tag);
        update = 1'b0;
    endtask

    initial begin
        bit seen;
        rst      = 1'b1;
        en       = 1'b0;
        update   = 1'b0;
        period   = '0;
        duty     = '0;
        deadtime = '0;
`ifdef PWM_FAULT_IN_EN
        fault     = 1'b0;
        fault_clr = 1'b0;
`endif
        modelReset();
        clearTally();

        runCycles(2, "reset");
        checkOutput("reset/low_all_ones", 8'(pwm_low), 8'hF);
        rst = 1'b0;

        // 10-cycle period, 3-cycle duty, no dead time.
        period = 16'd9;
        setDuty(0, 3);
        deadtime = 8'd0;
        pulseUpdate("p034_upd");
        en = 1'b1;
        runCycles(15, "p034_settle");
        clearTally();
        runCycles(20, "p034");
        checkOutput("p034/high0_count", 8'(t_high[0]), 8'd6);
        checkOutput("p034/low0_count", 8'(t_low[0]), 8'd14);
        checkOutput("p034/tick_count", 8'(t_tick), 8'd2);

        // Dead time of 2 on a 5/10 duty.
        setDuty(0, 5);
        deadtime = 8'd2;
        pulseUpdate("p035_upd");
        runCycles(25, "p035_settle");
        clearTally();
        runCycles(20, "p035");
        checkOutput("p035/high0_count", 8'(t_high[0]), 8'd6);
        checkOutput("p035/low0_count", 8'(t_low[0]), 8'd6);
        checkOutput("p035/off0_count", 8'(t_off[0]), 8'd8);

        // Duty extremes: 0 stays low, above period stays high.
        setDuty(0, 0);
        setDuty(1, 20);
        pulseUpdate("p036_upd");
        runCycles(25, "p036_settle");
        clearTally();
        runCycles(20, "p036");
        checkOutput("p036/low0_count", 8'(t_low[0]), 8'd20);
        checkOutput("p036/high1_count", 8'(t_high[1]), 8'd20);
        checkOutput("p036/off1_count", 8'(t_off[1]), 8'd0);

        // Mid-period update waits for the wrap.
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            applyStimulus("p037_sync");
            if (tick === 1'b1) seen = 1'b1;
        end
        checkOutput("p037/tick_seen", 8'(seen), 8'd1);
        runCycles(3, "p037_mid");
        setDuty(0, 7);
        pulseUpdate("p037_upd");
        checkOutput("p037/pending_set", 8'(pending), 8'd1);
        seen = 1'b0;
        for (int i = 0; i < 15 && !seen; i++) begin
            applyStimulus("p037_wait");
            if (tick === 1'b1) seen = 1'b1;
        end
        checkOutput("p037/wrap_seen", 8'(seen), 8'd1);
        checkOutput("p037/pending_clr", 8'(pending), 8'd0);
        runCycles(10, "p037_settle");
        clearTally();
        runCycles(20, "p037");
        checkOutput("p037/high0_count", 8'(t_high[0]), 8'd10);

        // Reset landing in the middle of a dead band.
        deadtime = 8'd3;
        pulseUpdate("p038_upd");
        runCycles(25, "p038_settle");
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            applyStimulus("p038_find");
            if (pwm_high[0] === 1'b0 && pwm_low[0] === 1'b0) seen = 1'b1;
        end
        checkOutput("p038/dead_seen", 8'(seen), 8'd1);
        rst = 1'b1;
        applyStimulus("p038_rst");
        checkOutput("p038/high_zero", 8'(pwm_high), 8'h0);
        checkOutput("p038/low_ones", 8'(pwm_low), 8'hF);
        rst = 1'b0;

`ifdef PWM_FAULT_IN_EN
        period = 16'd9;
        setDuty(0, 5);
        deadtime = 8'd1;
        pulseUpdate("fault_upd");
        runCycles(14, "fault_settle");
        fault = 1'b1;
        applyStimulus("fault_set");
        fault = 1'b0;
        checkOutput("fault/outputs_off", 8'(pwm_high | pwm_low), 8'h0);
        runCycles(5, "fault_hold");
        checkOutput("fault/still_off", 8'(pwm_high | pwm_low), 8'h0);
        fault     = 1'b1;
        fault_clr = 1'b1;
        applyStimulus("fault_both");
        fault     = 1'b0;
        runCycles(2, "fault_kept");
        checkOutput("fault/kept", 8'(pwm_high | pwm_low), 8'h0);
        applyStimulus("fault_clr");
        fault_clr = 1'b0;
        runCycles(12, "fault_after");
`endif

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 249) == 0);
            en     = ($urandom_range(0, 9) != 0);
            update = ($urandom_range(0, 11) == 0);
            if (update) begin
                period   = CNT_W'($urandom_range(0, 15));
                deadtime = DT_W'($urandom_range(0, 4));
                for (int k = 0; k < N_CH; k++) setDuty(k, int'($urandom_range(0, 20)));
            end
`ifdef PWM_FAULT_IN_EN
            fault     = ($urandom_range(0, 99) == 0);
            fault_clr = ($urandom_range(0, 14) == 0);
`endif
            applyStimulus("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
